exu_div_ctl: RTL and testbench
==============================

// Module: exu_div_ctl
// PURPOSE
//  Iterative radix-2 32-bit integer divider for RV32M DIV/DIVU/REM/REMU, the inverse-operation companion to the
//  pipelined multiplier in the EXU. Accepts one operation at a time from decode, runs a restoring shift-subtract
//  loop of 32 iterations, applies sign fixup, and returns a one-cycle finish pulse with the 32-bit result for writeback.
// PARAMETERS
//  none (width fixed at 32; iteration count fixed at 32)
// PORTS
//  clk          in   1   core clock
//  rst_l        in   1   reset, asynchronous, active-low
//  freeze       in   1   pipeline freeze: hold all state, suppress accept and finish
//  flush        in   1   cancel in-flight op (kill/flush from decode/TLU)
//  valid_in     in   1   start request; sampled only when busy=0
//  sign_in      in   1   1=signed (DIV/REM), 0=unsigned (DIVU/REMU)
//  rem_in       in   1   1=return remainder, 0=return quotient
//  a            in   32  dividend (rs1)
//  b            in   32  divisor (rs2)
//  busy         out  1   op in flight; decode must not assert valid_in while 1
//  finish       out  1   one-cycle pulse: out holds valid result
//  out          out  32  result; holds last value until next finish
// BEHAVIOUR
//  - Reset (rst_l=0, any time, async): state=IDLE, busy=0, finish=0, out=0, counter=0; in-flight op discarded.
//  - States: IDLE -> ITER (32 cycles, count 0..31) -> FIX (1 cycle) -> IDLE.
//  - Accept: cycle 0 when state=IDLE & valid_in & ~flush & ~freeze. Latch sign/rem flags, |a|,|b| (magnitudes when
//    signed & operand[31]=1; else raw), neg_q = sign & (a[31]^b[31]) & (b!=0), neg_r = sign & a[31].
//  - ITER: each cycle shift {rem,quo} left 1, trial subtract 33-bit rem-|b|; if non-negative keep and set quo bit0=1.
//  - FIX: quo/rem two's-complement negated per neg_q/neg_r; select by rem flag; register into out.
//  - Latency: busy=1 cycles 1..33; finish=1 in cycle 34 only; busy=0 in cycle 34 (new valid_in accepted there).
//  - Divide by zero: quotient=32'hFFFF_FFFF, remainder=a (falls out of algorithm; neg_q forced 0).
//  - Overflow a=32'h8000_0000, b=32'hFFFF_FFFF signed: quotient=32'h8000_0000, remainder=0.
//  - flush while busy: next cycle state=IDLE, busy=0, no finish, out unchanged. flush in cycle 34 does not retract
//    finish. flush with valid_in in cycle 0: op not accepted.
//  - freeze: state, counter, datapath and out held; finish not asserted while freeze=1 and re-presented
//    after freeze deasserts (finish never lost, never doubled).
//  - valid_in while busy=1: ignored (protocol violation; assertion in bench).
//  - Counter wrap: 5-bit count 31 -> FIX, never wraps to 0 while in ITER.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined: in cycle 1, if b==0 or |a|<|b| the op skips ITER; result computed directly
//    (q=0 or all-ones/signed rule above, r=a); finish=1 in cycle 2, busy=1 cycle 1 only. Other ops unchanged.
//  DIV_EARLY_OUT_EN undefined: every op takes full 34-cycle latency; no comparator logic.
// TESTING
//  DIVU a=100,b=7 -> finish in cycle 34, out=14; REMU same -> out=2; busy high cycles 1..33.
//  DIV a=-100,b=7 -> out=32'hFFFF_FFF2 (-14); REM a=-100,b=7 -> out=32'hFFFF_FFFE (-2).
//  DIV a=5,b=0 -> out=32'hFFFF_FFFF; REM a=5,b=0 -> out=5; DIV 32'h8000_0000/-1 -> out=32'h8000_0000, REM -> 0.
//  Start DIVU 100/7, flush in cycle 10 -> busy=0 cycle 11, no finish; new op cycle 11 -> finish cycle 45.
//  Start op, freeze cycles 5..14, then release -> finish in cycle 44, single pulse, correct value.
//  DIV_EARLY_OUT_EN: DIVU 3/10 -> finish cycle 2, out=0; REMU 3/10 -> out=3; disabled -> finish cycle 34.
//  rst_l low during ITER -> busy/finish/out=0 immediately; subsequent op completes normally.

Source files
------------

// File: rtl/exu_div_ctl.sv
// exu_div_ctl: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU (optional early-out: DIV_EARLY_OUT_EN)
module exu_div_ctl (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        freeze,
    input  logic        flush,
    input  logic        valid_in,
    input  logic        sign_in,
    input  logic        rem_in,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        finish,
    output logic [31:0] out
);
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d, rem_q, rem_d, div_q, div_d, out_q, out_d;
    logic        remf_q, remf_d, negq_q, negq_d, negr_q, negr_d, fin_q, fin_d;
    logic [32:0] shifted;
    logic [33:0] diff;
    logic        ge;
    logic [31:0] abs_a, abs_b, q_fix, r_fix;
    assign busy    = state_q != IDLE;
    assign finish  = fin_q & ~freeze;
    assign out     = out_q;
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = {1'b0, shifted} - {2'b0, div_q};
    assign ge      = ~diff[33];
    assign abs_a   = (sign_in & a[31]) ? -a : a;
    assign abs_b   = (sign_in & b[31]) ? -b : b;
    assign q_fix   = negq_q ? -quo_q : quo_q;
    assign r_fix   = negr_q ? -rem_q : rem_q;
    // next-state, datapath step and result selection; a pending finish is held across freeze
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        div_d   = div_q;
        out_d   = out_q;
        remf_d  = remf_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        fin_d   = fin_q & freeze;
        if (flush && busy) begin
            state_d = IDLE;
        end else if (!freeze) begin
            case (state_q)
                IDLE: if (valid_in && !flush) begin
                    state_d = ITER;
                    cnt_d   = 5'd0;
                    quo_d   = abs_a;
                    rem_d   = 32'd0;
                    div_d   = abs_b;
                    remf_d  = rem_in;
                    negq_d  = sign_in & (a[31] ^ b[31]) & (b != 32'd0);
                    negr_d  = sign_in & a[31];
                end
                ITER: begin
`ifdef DIV_EARLY_OUT_EN
                    if (cnt_q == 5'd0 && (div_q == 32'd0 || quo_q < div_q)) begin
                        out_d   = remf_q ? (negr_q ? -quo_q : quo_q) : {32{div_q == 32'd0}};
                        fin_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rem_d   = ge ? diff[31:0] : shifted[31:0];
                        quo_d   = {quo_q[30:0], ge};
                        cnt_d   = cnt_q + 5'd1;
                        state_d = (cnt_q == 5'd31) ? FIX : ITER;
                    end
`else
                    rem_d   = ge ? diff[31:0] : shifted[31:0];
                    quo_d   = {quo_q[30:0], ge};
                    cnt_d   = cnt_q + 5'd1;
                    state_d = (cnt_q == 5'd31) ? FIX : ITER;
`endif
                end
                FIX: begin
                    out_d   = remf_q ? r_fix : q_fix;
                    fin_d   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            quo_q   <= 32'd0;
            rem_q   <= 32'd0;
            div_q   <= 32'd0;
            out_q   <= 32'd0;
            remf_q  <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            out_q   <= out_d;
            remf_q  <= remf_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            fin_q   <= fin_d;
        end
    end
endmodule

// File: tb/tb_exu_div_ctl.sv
// tb_exu_div_ctl: randomized and directed checks of exu_div_ctl against an arithmetic reference model
module tb_exu_div_ctl;
    logic        clk = 0, rst_l = 0, freeze = 0, flush = 0, valid_in = 0, sign_in = 0, rem_in = 0;
    logic [31:0] a = 0, b = 0;
    logic        busy, finish;
    logic [31:0] out;
    int          checks = 0, errors = 0, cyc = 0;

    exu_div_ctl dut (.clk(clk), .rst_l(rst_l), .freeze(freeze), .flush(flush), .valid_in(valid_in),
                     .sign_in(sign_in), .rem_in(rem_in), .a(a), .b(b), .busy(busy), .finish(finish), .out(out));

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_l) assert (!(busy && valid_in)) else $error("protocol: valid_in while busy");

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(bit s, bit r, logic [31:0] x, logic [31:0] y);
        longint sx, sy;
        if (y == 0) return r ? x : 32'hFFFF_FFFF;
        if (!s) return r ? x % y : x / y;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return r ? 32'(sx % sy) : 32'(sx / sy);
    endfunction

    function automatic int ref_lat(bit s, logic [31:0] x, logic [31:0] y);
`ifdef DIV_EARLY_OUT_EN
        logic [31:0] mx, my;
        mx = (s && x[31]) ? 32'(0 - x) : x;
        my = (s && y[31]) ? 32'(0 - y) : y;
        return (y == 0 || mx < my) ? 2 : 34;
`else
        return 34;
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(bit s, bit r, logic [31:0] x, logic [31:0] y);
        sign_in = s; rem_in = r; a = x; b = y; valid_in = 1;
    endtask

    task automatic run_op(string tag, bit s, bit r, logic [31:0] x, logic [31:0] y);
        int lat = 0, bc = 0, fins = 0;
        logic [31:0] res = 0;
        @(negedge clk);
        drive(s, r, x, y);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            valid_in = 0;
            if (busy) bc++;
            if (finish) begin
                fins++;
                if (lat == 0) begin lat = k; res = out; end
            end
        end
        chk({tag, " lat"}, lat, ref_lat(s, x, y));
        chk({tag, " busy"}, bc, ref_lat(s, x, y) - 1);
        chk({tag, " pulses"}, fins, 1);
        chk({tag, " val"}, res, ref_res(s, r, x, y));
    endtask

    task automatic run_frz(string tag, int lo, int hi, int exp_cyc);
        int fc = 0, fins = 0;
        logic [31:0] res = 0;
        @(negedge clk);
        cyc = 0;
        drive(0, 0, 1000, 33);
        for (int k = 1; k <= 60; k++) begin
            tick();
            valid_in = 0;
            freeze = (cyc >= lo && cyc <= hi);
            #1;
            if (finish) begin
                fins++;
                if (fc == 0) begin fc = cyc; res = out; end
            end
        end
        chk({tag, " cyc"}, fc, exp_cyc);
        chk({tag, " pulses"}, fins, 1);
        chk({tag, " val"}, res, 32'd30);
    endtask

    initial begin
        logic [31:0] prev, x, y;
        int fc, fins;
        bit s, r;
        repeat (3) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst finish", finish, 0);
        chk("rst out", out, 0);
        rst_l = 1;
        run_op("divu", 0, 0, 100, 7);
        run_op("remu", 0, 1, 100, 7);
        run_op("div neg", 1, 0, -100, 7);
        run_op("rem neg", 1, 1, -100, 7);
        run_op("div0", 1, 0, 5, 0);
        run_op("rem0", 1, 1, 5, 0);
        run_op("divu0", 0, 0, 32'h8000_0001, 0);
        run_op("ovf div", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("ovf rem", 1, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("small q", 0, 0, 3, 10);
        run_op("small r", 0, 1, 3, 10);
        run_op("sneg b", 1, 1, 7, -3);
        for (int i = 0; i < 60; i++) begin
            s = 1'($urandom);
            r = 1'($urandom);
            case ($urandom_range(0, 3))
                0: y = 0;
                1: y = $urandom_range(1, 15);
                2: y = -$urandom_range(1, 15);
                default: y = $urandom;
            endcase
            x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            if ($urandom_range(0, 3) == 0) x = $urandom_range(0, 20);
            run_op("rand", s, r, x, y);
        end
        // flush mid-operation, then restart the cycle after
        @(negedge clk);
        cyc = 0;
        prev = out;
        drive(0, 0, 100, 7);
        tick();
        valid_in = 0;
        while (cyc < 10) tick();
        flush = 1;
        tick();
        flush = 0;
        chk("flush busy", busy, 0);
        chk("flush out", out, prev);
        chk("flush fin", finish, 0);
        drive(0, 0, 200, 9);
        fc = 0;
        fins = 0;
        while (cyc < 50) begin
            tick();
            valid_in = 0;
            if (finish) begin fins++; if (fc == 0) fc = cyc; end
        end
        chk("restart cyc", fc, 45);
        chk("restart pulses", fins, 1);
        chk("restart val", out, 22);
        run_frz("frz mid", 5, 14, 44);
        run_frz("frz fin", 34, 37, 38);
        // flush coinciding with valid_in: not accepted
        @(negedge clk);
        drive(0, 0, 9, 2);
        flush = 1;
        @(negedge clk);
        valid_in = 0;
        flush = 0;
        chk("flush accept", busy, 0);
        fins = 0;
        repeat (40) begin
            @(negedge clk);
            if (finish) fins++;
        end
        chk("flush accept fin", fins, 0);
        // asynchronous reset in the middle of an op
        @(negedge clk);
        drive(0, 0, 1000, 3);
        @(negedge clk);
        valid_in = 0;
        repeat (8) @(negedge clk);
        #2 rst_l = 0;
        #1;
        chk("arst busy", busy, 0);
        chk("arst finish", finish, 0);
        chk("arst out", out, 0);
        @(negedge clk);
        rst_l = 1;
        run_op("post rst", 1, 0, -1000, 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
